// File: rtl/pdm_mixer_n.sv
// N-channel sigma-delta audio mixer. Each channel's pulse density is gated by a PWM volume
// envelope, and the channels are summed into one tristate bitstream with zero-crossing hysteresis.
module pdm_mixer_n #(
  parameter int NCH    = 4,
  parameter int SW     = 8,
  parameter int VW     = 7,
  parameter int STRONG = (NCH / 2 < 1) ? 1 : NCH / 2,
  parameter bit DITHER = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH*SW-1:0] sample,
  input  logic [NCH*VW-1:0] vol,
  input  logic              load,
  input  logic              lfsr,
  output logic              frame,
  output logic              bs_d,
  output logic              bs_oe
);

  localparam int CW = VW - 1;
  localparam int AW = SW + 1;
  localparam int NW = $clog2(NCH + 1) + 1;
  localparam logic [CW-1:0]        CNT_MAX  = '1;
  localparam logic signed [NW-1:0] NET_ONE  = NW'(1);
  localparam logic [NW-1:0]        STRONG_N = NW'(STRONG);

  typedef enum logic [1:0] {
    LVL_NEG  = 2'b00,
    LVL_ZERO = 2'b01,
    LVL_POS  = 2'b10
  } lvl_e;

  logic [NCH*SW-1:0]    r_sh_smp, r_act_smp;
  logic [NCH*VW-1:0]    r_sh_vol, r_act_vol;
  logic [CW-1:0]        r_count;
  logic                 r_frame, r_bs_d, r_bs_oe;
  logic                 w_wrap, w_dith;
  logic [2*NCH-1:0]     w_lvl;
  logic signed [NW-1:0] w_net;
  logic [NW-1:0]        w_abs;
  logic                 w_nxt_oe, w_nxt_d;

  assign w_wrap = (r_count == CNT_MAX);
  assign w_dith = DITHER ? lfsr : 1'b0;

  // NOTE: non-blocking assignments so every register samples the values from before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh_smp  <= '0;
      r_sh_vol  <= '0;
      r_act_smp <= '0;
      r_act_vol <= '0;
      r_count   <= '0;
      r_frame   <= 1'b0;
      r_bs_oe   <= 1'b0;
      r_bs_d    <= 1'b0;
    end else begin
      r_count <= r_count + 1'b1;
      r_frame <= w_wrap;
      r_bs_oe <= w_nxt_oe;
      r_bs_d  <= w_nxt_d;
      if (load) begin
        r_sh_smp <= sample;
        r_sh_vol <= vol;
      end
      // A load on the wrap cycle bypasses the shadow so it still lands in the coming frame.
      if (w_wrap) begin
        r_act_smp <= load ? sample : r_sh_smp;
        r_act_vol <= load ? vol    : r_sh_vol;
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [SW-1:0] w_as;
    logic [VW-1:0] w_av;
    logic [SW-1:0] w_mag;
    logic [AW-1:0] r_acc;
    logic          r_pwm, r_sgn;
    lvl_e          r_lvl;

    assign w_as  = r_act_smp[k*SW +: SW];
    assign w_av  = r_act_vol[k*VW +: VW];
    assign w_mag = {w_as[SW-2:0], w_dith} ^ {SW{w_as[SW-1]}};

    // The sign travels with acc/pwm so the level stage sees one consistent sample.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_acc <= '0;
        r_pwm <= 1'b0;
        r_sgn <= 1'b0;
        r_lvl <= LVL_ZERO;
      end else begin
        r_acc <= AW'(r_acc[SW-1:0]) + AW'(w_mag) + AW'(r_acc[SW]);
        r_pwm <= w_av[VW-1] | (r_count < w_av[VW-2:0]);
        r_sgn <= w_as[SW-1];
        if (!r_pwm || !r_acc[SW]) r_lvl <= LVL_ZERO;
        else                      r_lvl <= r_sgn ? LVL_NEG : LVL_POS;
      end
    end

    assign w_lvl[2*k +: 2] = r_lvl;
  end

  // NOTE: every signal gets a default before any branch, so no path can infer a latch.
  always_comb begin
    w_net    = '0;
    w_nxt_oe = 1'b0;
    w_nxt_d  = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (w_lvl[2*k +: 2] == LVL_POS)      w_net = w_net + NET_ONE;
      else if (w_lvl[2*k +: 2] == LVL_NEG) w_net = w_net - NET_ONE;
    end
    w_abs = w_net[NW-1] ? -w_net : w_net;
    // A weak level never flips the polarity directly; it passes through one Z cycle first.
    if (w_net != '0) begin
      if (!(w_abs < STRONG_N && r_bs_oe && (r_bs_d == w_net[NW-1]))) begin
        w_nxt_oe = 1'b1;
        w_nxt_d  = ~w_net[NW-1];
      end
    end
  end

  assign frame = r_frame;
  assign bs_d  = r_bs_d;
  assign bs_oe = r_bs_oe;

endmodule

// File: tb/tb_pdm_mixer_n.sv
// Bench for pdm_mixer_n at default parameters: a vector table of steady-state frame patterns
// plus hand sequences for load timing, zero crossing, cancellation and reset.
module tb_pdm_mixer_n;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] sample;
  logic [27:0] vol;
  logic        load, lfsr;
  logic        frame, bs_d, bs_oe;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic [63:0] oe;
    logic [63:0] d;
    logic [63:0] fr;
  } exp_t;

  typedef struct {
    logic [31:0] smp;
    logic [27:0] vl;
    logic        dith;
    int          duty;
    logic        pos;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[8];

  pdm_mixer_n dut (
    .clk    (clk),
    .reset  (reset),
    .sample (sample),
    .vol    (vol),
    .load   (load),
    .lfsr   (lfsr),
    .frame  (frame),
    .bs_d   (bs_d),
    .bs_oe  (bs_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bit p: bs driven at frame position p; positions 0..2 still carry the previous frame's tail.
  function automatic logic [63:0] duty_mask(input int d_old, input int d_new);
    logic [63:0] m;
    m = '0;
    for (int p = 0; p < 64; p++) begin
      int c;
      c = (p + 61) % 64;
      m[p] = (p < 3) ? (c < d_old) : (c < d_new);
    end
    return m;
  endfunction

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame && n < 200);
    if (!frame) begin
      n_total++;
      n_bad++;
      $display("FAIL wait_frame: no frame pulse within %0d cycles", n);
    end
  endtask

  task automatic do_load(input logic [31:0] smp, input logic [27:0] vl, input logic dith);
    sample = smp;
    vol    = vl;
    lfsr   = dith;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  task automatic apply(input logic [31:0] smp, input logic [27:0] vl, input logic dith,
                       input int at_pos);
    wait_frame();
    repeat (at_pos) @(negedge clk);
    do_load(smp, vl, dith);
  endtask

  task automatic push_exp(input logic [63:0] oe, input logic [63:0] d, input logic [63:0] fr);
    exp_t e;
    e.oe = oe;
    e.d  = d;
    e.fr = fr;
    sb_q.push_back(e);
  endtask

  task automatic run_check(input string name, input int n);
    logic [63:0] oe_m, d_m, fr_m;
    exp_t e;
    oe_m = '0;
    d_m  = '0;
    fr_m = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      oe_m[i] = bs_oe;
      d_m[i]  = bs_d;
      fr_m[i] = frame;
    end
    if (sb_q.size() == 0) begin
      n_total++;
      n_bad++;
      $display("FAIL %s: scoreboard empty, got oe=%h", name, oe_m);
    end else begin
      e = sb_q.pop_front();
      check({name, "_oe"}, oe_m, e.oe);
      check({name, "_d"},  d_m,  e.d);
      check({name, "_fr"}, fr_m, e.fr);
    end
  endtask

  initial begin
    logic [63:0] m;
    int          z, k;
    logic        any_oe;

    tbl[0] = '{{8'h00, 8'h00, 8'h00, 8'h7F}, {7'h00, 7'h00, 7'h00, 7'h40}, 1'b1, 64, 1'b1};
    tbl[1] = '{{8'h00, 8'h00, 8'h00, 8'h7F}, {7'h00, 7'h00, 7'h00, 7'h10}, 1'b1, 16, 1'b1};
    tbl[2] = '{{8'h00, 8'h00, 8'h00, 8'h80}, {7'h00, 7'h00, 7'h00, 7'h20}, 1'b0, 32, 1'b0};
    tbl[3] = '{{8'h00, 8'h7F, 8'h7F, 8'h7F}, {7'h00, 7'h01, 7'h2A, 7'h05}, 1'b1, 42, 1'b1};
    tbl[4] = '{{8'h80, 8'h80, 8'h80, 8'h80}, {7'h10, 7'h41, 7'h00, 7'h3F}, 1'b0, 64, 1'b0};
    tbl[5] = '{{8'h7F, 8'h7F, 8'h7F, 8'h7F}, {7'h00, 7'h00, 7'h00, 7'h00}, 1'b1, 0,  1'b0};
    tbl[6] = '{{8'h80, 8'h00, 8'h00, 8'h00}, {7'h01, 7'h00, 7'h00, 7'h00}, 1'b0, 1,  1'b0};
    tbl[7] = '{{8'h00, 8'h7F, 8'h00, 8'h00}, {7'h00, 7'h3F, 7'h00, 7'h00}, 1'b1, 63, 1'b1};

    reset  = 1'b1;
    sample = '0;
    vol    = '0;
    load   = 1'b0;
    lfsr   = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", {61'd0, bs_oe, bs_d, frame}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].smp, tbl[i].vl, tbl[i].dith, 1 + 7 * i);
      m = duty_mask(tbl[i].duty, tbl[i].duty);
      push_exp(m, tbl[i].pos ? m : 64'd0, 64'h1);
      wait_frame();
      wait_frame();
      run_check($sformatf("vec%0d", i), 64);
    end

    // New volume loaded at count 10 must leave the rest of the running frame untouched.
    apply({8'h00, 8'h00, 8'h00, 8'h7F}, {7'h00, 7'h00, 7'h00, 7'h10}, 1'b1, 5);
    wait_frame();
    wait_frame();
    repeat (10) @(negedge clk);
    do_load({8'h00, 8'h00, 8'h00, 8'h7F}, {7'h00, 7'h00, 7'h00, 7'h30}, 1'b1);
    m = '0;
    for (int i = 0; i < 53; i++) m[i] = ((11 + i - 3) < 16);
    push_exp(m, m, 64'd0);
    run_check("midload_hold", 53);
    wait_frame();
    push_exp(duty_mask(16, 48), duty_mask(16, 48), 64'h1);
    run_check("midload_take", 64);
    do_load({8'h00, 8'h00, 8'h00, 8'h7F}, {7'h00, 7'h00, 7'h00, 7'h08}, 1'b1);
    push_exp(duty_mask(48, 8), duty_mask(48, 8), 64'h1);
    run_check("wrap_load", 64);
    wait_frame();
    push_exp(duty_mask(8, 8), duty_mask(8, 8), 64'h1);
    run_check("wrap_shadow", 64);

    // Strong +4 to weak -1 must pass through exactly one Z cycle.
    apply({4{8'h7F}}, {4{7'h40}}, 1'b1, 5);
    wait_frame();
    wait_frame();
    repeat (20) @(negedge clk);
    do_load({8'h7F, 8'h7F, 8'h7F, 8'h80}, {7'h00, 7'h00, 7'h00, 7'h40}, 1'b1);
    wait_frame();
    lfsr = 1'b0;
    push_exp(64'h7F7, 64'h007, 64'h1);
    run_check("zero_cross", 11);
    repeat (10) @(negedge clk);
    do_load({4{8'h7F}}, {4{7'h40}}, 1'b0);
    wait_frame();
    lfsr = 1'b1;
    push_exp(64'h7FF, 64'h7F8, 64'h1);
    run_check("weak_to_strong", 11);
    repeat (10) @(negedge clk);
    do_load({4{8'h80}}, {4{7'h40}}, 1'b1);
    wait_frame();
    lfsr = 1'b0;
    push_exp(64'h7FF, 64'h007, 64'h1);
    run_check("strong_reverse", 11);

    // Equal and opposite channels cancel almost everywhere.
    apply({8'h00, 8'h00, 8'h80, 8'h7F}, {7'h00, 7'h00, 7'h40, 7'h40}, 1'b1, 20);
    wait_frame();
    wait_frame();
    z = 0;
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge clk);
      if (!bs_oe) z++;
    end
    n_total++;
    if (z < 254) begin
      n_bad++;
      $display("FAIL cancel_z: z_cycles=%0d required>=254", z);
    end

    // Asynchronous reset on a frame pulse with the output strongly driven.
    apply({4{8'h7F}}, {4{7'h40}}, 1'b1, 5);
    wait_frame();
    wait_frame();
    check("pre_reset", {61'd0, bs_oe, bs_d, frame}, 64'd7);
    #2 reset = 1'b1;
    #1 check("reset_async", {61'd0, bs_oe, bs_d, frame}, 64'd0);
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    k      = 0;
    any_oe = 1'b0;
    do begin
      @(negedge clk);
      k++;
      any_oe = any_oe | bs_oe;
    end while (!frame && k < 200);
    check("frame_after_reset", 64'(k), 64'd64);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      any_oe = any_oe | bs_oe;
    end
    check("z_after_reset", {63'd0, any_oe}, 64'd0);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
